// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the fully-connected layer sequencer.
package fc_pkg;
    localparam int unsigned N_STEP = 36;
    localparam int unsigned N_LANE = 3;
    localparam int unsigned ACC_W  = 10;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned FEAT_W = 2 * N_LANE;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        FLUSH,
        SETTLE,
        OUT
    } fc_state_t;
endpackage

// File: rtl/fc_seq_ctrl_vad_decide.sv
// Combinational VAD score (acc1 - acc0, one guard bit) and strict threshold compare.
module vad_decide #(
    parameter int unsigned ACC_W  = fc_pkg::ACC_W,
    parameter int          THRESH = 0
) (
    input  logic signed [ACC_W-1:0] i_acc0,
    input  logic signed [ACC_W-1:0] i_acc1,
    output logic signed [ACC_W:0]   o_score,
    output logic                    o_vad_flag
);
    localparam logic signed [ACC_W:0] TH = (ACC_W+1)'(THRESH);

    assign o_score    = (ACC_W+1)'(i_acc1) - (ACC_W+1)'(i_acc0);
    assign o_vad_flag = (o_score > TH);
endmodule

// File: rtl/fc_seq_ctrl.sv
// Frame sequencer: clears the MAC, streams N_STEP feature words into it,
// then captures the VAD score/flag and offers it on a valid/ready port.
module fc_seq_ctrl #(
    parameter int unsigned N_STEP = fc_pkg::N_STEP,
    parameter int unsigned ADDR_W = fc_pkg::ADDR_W,
    parameter int unsigned ACC_W  = fc_pkg::ACC_W,
    parameter int          THRESH = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic                         busy,
    output logic                         feat_rd_en,
    output logic [ADDR_W-1:0]            feat_addr,
    input  logic [fc_pkg::FEAT_W-1:0]    feat_data,
    output logic                         mac_clr,
    output logic                         mac_en,
    output logic [fc_pkg::FEAT_W-1:0]    mac_in,
    output logic [ADDR_W-1:0]            step_idx,
    input  logic signed [ACC_W-1:0]      acc0,
    input  logic signed [ACC_W-1:0]      acc1,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [ACC_W:0]        score,
    output logic                         vad_flag
);
    import fc_pkg::*;

    fc_state_t               r_state;
    fc_state_t               w_state_nxt;
    logic [ADDR_W-1:0]       w_addr_nxt;
    logic                    w_capture;
    logic                    w_abort;
    logic                    w_last;
    logic signed [ACC_W:0]   w_score;
    logic                    w_vad_flag;

    logic                    r_busy;
    logic                    r_feat_rd_en;
    logic [ADDR_W-1:0]       r_feat_addr;
    logic                    r_mac_clr;
    logic                    r_mac_en;
    logic [ADDR_W-1:0]       r_step_idx;
    logic                    r_res_valid;
    logic signed [ACC_W:0]   r_score;
    logic                    r_vad_flag;

    assign w_abort = abort && (r_state != IDLE);
    assign w_last  = (r_feat_addr == ADDR_W'(N_STEP - 1));

    vad_decide #(
        .ACC_W  (ACC_W),
        .THRESH (THRESH)
    ) u_vad_decide (
        .i_acc0     (acc0),
        .i_acc1     (acc1),
        .o_score    (w_score),
        .o_vad_flag (w_vad_flag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_feat_addr;
        w_capture   = 1'b0;
        case (r_state)
            IDLE:   if (start) w_state_nxt = CLR;
            CLR: begin
                w_state_nxt = RUN;
                w_addr_nxt  = '0;
            end
            RUN: begin
                if (w_last) w_state_nxt = FLUSH;
                else        w_addr_nxt  = r_feat_addr + ADDR_W'(1);
            end
            FLUSH:  w_state_nxt = SETTLE;
            SETTLE: begin
                w_state_nxt = OUT;
                w_capture   = 1'b1;
            end
            OUT:    if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Abort wins over every other transition and suppresses the capture.
        if (w_abort) begin
            w_state_nxt = IDLE;
            w_capture   = 1'b0;
        end
    end

    // Outputs registered from the next state; the read pipeline lags one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_feat_rd_en <= 1'b0;
            r_feat_addr  <= '0;
            r_mac_clr    <= 1'b0;
            r_mac_en     <= 1'b0;
            r_step_idx   <= '0;
            r_res_valid  <= 1'b0;
            r_score      <= '0;
            r_vad_flag   <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != IDLE);
            r_feat_rd_en <= (w_state_nxt == RUN);
            r_feat_addr  <= w_addr_nxt;
            r_mac_clr    <= (w_state_nxt == CLR);
            r_mac_en     <= r_feat_rd_en && !w_abort;
            r_step_idx   <= r_feat_addr;
            r_res_valid  <= (w_state_nxt == OUT);
            if (w_capture) begin
                r_score    <= w_score;
                r_vad_flag <= w_vad_flag;
            end
        end
    end

    assign busy       = r_busy;
    assign feat_rd_en = r_feat_rd_en;
    assign feat_addr  = r_feat_addr;
    assign mac_clr    = r_mac_clr;
    assign mac_en     = r_mac_en;
    // Buffer read data arrives in the mac_en cycle; gate it so idle cycles read as zero.
    assign mac_in     = r_mac_en ? feat_data : '0;
    assign step_idx   = r_step_idx;
    assign res_valid  = r_res_valid;
    assign score      = r_score;
    assign vad_flag   = r_vad_flag;
endmodule

// File: doc/fc_seq_ctrl.md
Name: fc_seq_ctrl

Overview:
- Sequencer for the fully-connected layer datapath (3-lane, 2-bit activation, 2-output MAC) in the BNN-VAD pipeline.
- On a start pulse it clears the MAC, streams 36 feature triplets from the feature buffer into the MAC, then captures the two accumulators.
- From the captured accumulators it forms the VAD score and speech flag, and presents them on a valid/ready result port.
- Sits between the feature buffer and the frame-level VAD post-processing.

Parameters:
- N_STEP, 36, MAC steps per frame; also the number of feature-buffer words.
- ADDR_W, 6, feature-buffer address and step-index width.
- ACC_W, 10, signed accumulator width of each MAC output.
- THRESH, 0, signed decision threshold applied to the score.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process one frame.
- abort  in  1  synchronous abandon of the current frame.
- busy  out  1  high in every state other than IDLE.
- feat_rd_en  out  1  feature-buffer read strobe.
- feat_addr  out  ADDR_W  feature-buffer word address.
- feat_data  in  6  read data {lane3,lane2,lane1}, 2 bits per lane, returned 1 cycle after feat_rd_en.
- mac_clr  out  1  clear the MAC accumulators and step counter.
- mac_en  out  1  MAC accumulate enable for this cycle.
- mac_in  out  6  lane operands {lane3,lane2,lane1} to the MAC.
- step_idx  out  ADDR_W  weight step index for the MAC, aligned with mac_en.
- acc0  in  ACC_W signed  MAC output 1.
- acc1  in  ACC_W signed  MAC output 2.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- score  out  ACC_W+1 signed  acc1 - acc0.
- vad_flag  out  1  speech decision.

Behaviour:
- States: IDLE, CLR, RUN, FLUSH, SETTLE, OUT.
- Reset (any time, including mid-frame): state IDLE; all outputs 0, including score, vad_flag, feat_addr, step_idx and mac_in.
- IDLE: start=1 -> CLR. A start arriving while busy=1 is ignored, not queued.
- CLR: one cycle with mac_clr=1, then -> RUN. The read address counter is reset to 0.
- RUN: feat_rd_en=1, feat_addr = 0..N_STEP-1, one address per cycle (exactly 36 cycles). After address N_STEP-1 -> FLUSH.
- Read pipeline: mac_en, mac_in and step_idx are the registered copies of feat_rd_en, feat_data and feat_addr, delayed one cycle.
  - mac_en is high for exactly N_STEP cycles per frame.
  - mac_in = 0 whenever mac_en = 0.
- FLUSH: one cycle. The last read returns and is accumulated. -> SETTLE.
- SETTLE: one cycle. The accumulators are final. At the end of this cycle, capture:
  - score = sign-extended acc1 minus sign-extended acc0, computed at ACC_W+1 bits so it cannot overflow.
  - vad_flag = (score > THRESH), strictly greater; equality gives 0.
  - Then -> OUT.
- OUT: res_valid=1; score and vad_flag held stable.
  - res_valid && res_ready -> IDLE. res_valid drops the next cycle.
  - A start in the accept cycle is ignored.
- Latency: start sampled at edge E0 -> res_valid high after edge E39 (39 cycles). If res_ready is held high, the next start is accepted 1 cycle after the handshake.
- abort=1 in CLR/RUN/FLUSH/SETTLE/OUT -> IDLE on the next edge.
  - feat_rd_en, mac_en and res_valid are forced to 0 that cycle.
  - score and vad_flag keep their last captured value.
  - abort in IDLE has no effect.
  - abort has priority over start and over res_ready.
- score and vad_flag change only at the SETTLE capture edge or on reset.

Decomposition:
- Shared package fc_pkg:
  - constants N_STEP=36, N_LANE=3, ACC_W=10, FEAT_W=2*N_LANE.
  - state enum fc_state_t {IDLE, CLR, RUN, FLUSH, SETTLE, OUT}.
- Sub-module vad_decide: combinational score/threshold compare. Its result is registered in fc_seq_ctrl.
- The address counter stays inline.

Test Plan:
- Nominal frame: start pulse, buffer word k = 6'b010101, model MAC (all weights +1) -> 36 mac_en cycles, step_idx 0..35, res_valid after 39 cycles. acc1=108, acc0=0 gives score=108, vad_flag=1.
- Threshold boundary: THRESH=5, acc1=5, acc0=0 -> vad_flag=0. acc1=6 -> vad_flag=1. acc1=-512, acc0=511 -> score=-1023 (no overflow).
- Backpressure: res_ready low for 10 cycles -> res_valid, score and vad_flag stable. A start pulsed during OUT is ignored; after the handshake, busy=0.
- Abort mid-RUN: abort at feat_addr=17 -> IDLE next cycle, mac_en=0, res_valid never rises. The following start runs a full 36-step frame from addr 0.
- Async reset mid-FLUSH: rst asserted between edges -> all outputs 0 immediately, state IDLE. A frame started after rst release completes normally.
- Back-to-back frames: res_ready tied high, start re-pulsed 1 cycle after each handshake -> mac_clr precedes each frame and no stale mac_en appears between frames.
